// File: rtl/alu_stage_pkg.sv
// ---------------------------------------------------------------------------
// alu_stage_pkg
//   Shared definitions for the ALU writeback stage: the op-class encoding
//   carried alongside each ALU result, the overflow status codes written to
//   the status register, and small helpers used by the stage transform.
// ---------------------------------------------------------------------------
package alu_stage_pkg;

    typedef enum logic [2:0] {
        NOP   = 3'd0,
        ADD   = 3'd1,
        ADDI  = 3'd2,
        SUB   = 3'd3,
        LOGIC = 3'd4,
        SHIFT = 3'd5,
        BNE   = 3'd6,
        BLT   = 3'd7
    } op_e;

    // Status codes recorded in the status register when an arithmetic op overflows.
    localparam int ST_ADD  = 1;
    localparam int ST_ADDI = 2;
    localparam int ST_SUB  = 3;

    localparam int STATUS_REG_DEFAULT = 30;

    // Only these op classes can raise an overflow status.
    function automatic logic is_arith(input op_e op);
        return (op == ADD) || (op == ADDI) || (op == SUB);
    endfunction

    function automatic logic [1:0] status_code(input op_e op);
        case (op)
            ADD:     return 2'(ST_ADD);
            ADDI:    return 2'(ST_ADDI);
            SUB:     return 2'(ST_SUB);
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/skid_buffer_2.sv
// ---------------------------------------------------------------------------
// skid_buffer_2
//   Generic two-entry valid/ready buffer: an output register plus one skid
//   register. in_ready is registered (it is simply "skid entry empty"), so the
//   upstream ready path never combinationally depends on out_ready.
//
// Ports
//   clock      in   rising-edge clock
//   resetn     in   asynchronous active-low reset
//   flush      in   synchronous: invalidate both entries on the next edge
//   in_valid   in   upstream entry valid
//   in_ready   out  buffer can accept (skid entry empty)
//   in_data    in   upstream payload
//   out_valid  out  output entry valid
//   out_ready  in   downstream accepts
//   out_data   out  output payload (held while out_valid & ~out_ready)
// ---------------------------------------------------------------------------
module skid_buffer_2 #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    always_comb begin
        // NOTE: every signal gets a default first, so no branch leaves one unassigned and no latch is inferred.
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output register is free this edge. A held skid entry is older than
            // anything upstream, so it goes first; upstream cannot be accepted
            // in that cycle because in_ready is low while the skid is full.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_valid && !skid_valid_q) begin
            // Output stalled: park the new entry in the skid register.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // NOTE: payload registers are reset as well so the outputs read zero out of reset.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            // NOTE: sequential state is written with <= so every flop samples pre-edge values.
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// alu_writeback_stage
//   Execute->memory boundary stage directly downstream of the ALU. Each
//   incoming entry is transformed combinationally (overflow -> status write,
//   branch resolution, branch target), then registered through a two-entry
//   skid buffer. A saturating counter tracks accepted overflow entries.
//
// Ports
//   clock, resetn            clock / asynchronous active-low reset
//   flush                    discard all buffered entries on the next edge
//   in_valid / in_ready      upstream handshake (in_ready registered)
//   in_op                    op class
//   in_result, in_overflow,
//   in_not_equal,
//   in_less_than             ALU outputs
//   in_rd, in_pc, in_imm     destination register, PC, branch offset
//   out_valid / out_ready    downstream handshake
//   out_data, out_rd, out_we writeback value / register / enable
//   out_br_taken,
//   out_br_target            branch decision and pc + 1 + imm
//   ovf_count                saturating count of accepted overflow entries
// ---------------------------------------------------------------------------
module alu_writeback_stage
    import alu_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_W      = 5,
    parameter int CNT_W      = 8,
    parameter int STATUS_REG = STATUS_REG_DEFAULT
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  op_e               in_op,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_overflow,
    input  logic              in_not_equal,
    input  logic              in_less_than,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_we,
    output logic              out_br_taken,
    output logic [DATA_W-1:0] out_br_target,
    output logic [CNT_W-1:0]  ovf_count
);

    // Payload layout: {data, rd, we, taken, target}
    localparam int PAY_W = DATA_W + REG_W + 1 + 1 + DATA_W;

    logic [DATA_W-1:0] x_data;
    logic [REG_W-1:0]  x_rd;
    logic              x_we;
    logic              x_taken;
    logic              x_ovf;
    logic [DATA_W-1:0] x_target;

    logic [PAY_W-1:0]  in_payload;
    logic [PAY_W-1:0]  out_payload;

    logic [CNT_W-1:0]  ovf_cnt_q, ovf_cnt_d;

    // Transform applied to every entry as it is offered; only accepted entries matter.
    always_comb begin
        x_data  = in_result;
        x_rd    = in_rd;
        x_we    = 1'b0;
        x_taken = 1'b0;
        x_ovf   = 1'b0;

        case (in_op)
            ADD, ADDI, SUB: begin
                if (in_overflow) begin
                    // Overflow redirects the write to the status register.
                    x_ovf  = 1'b1;
                    x_data = DATA_W'(status_code(in_op));
                    x_rd   = REG_W'(STATUS_REG);
                    x_we   = 1'b1;
                end else begin
                    x_we = (in_rd != '0);
                end
            end
            LOGIC, SHIFT: x_we    = (in_rd != '0);
            BNE:          x_taken = in_not_equal;
            BLT:          x_taken = in_less_than;
            default:      ;
        endcase
    end

    // Wraps modulo 2^DATA_W by construction.
    assign x_target = in_pc + DATA_W'(1) + in_imm;

    assign in_payload = {x_data, x_rd, x_we, x_taken, x_target};

    skid_buffer_2 #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clock     (clock),
        .resetn    (resetn),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_payload),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_payload)
    );

    assign {out_data, out_rd, out_we, out_br_taken, out_br_target} = out_payload;

    // A flushed entry is discarded, so it must not be counted either.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (in_valid && in_ready && !flush && x_ovf && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_writeback_stage
//   Self-checking bench: a table of single-entry vectors, hand-written
//   sequences for back-pressure, flush, saturation and asynchronous reset,
//   then randomized traffic checked against a queue-based reference model.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_alu_writeback_stage;
    import alu_stage_pkg::*;

    logic        clock;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    op_e         in_op;
    logic [31:0] in_result;
    logic        in_overflow;
    logic        in_not_equal;
    logic        in_less_than;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_br_taken;
    logic [31:0] out_br_target;
    logic [7:0]  ovf_count;

    int checks   = 0;
    int failures = 0;
    int cnt_exp  = 0;

    alu_writeback_stage dut (
        .clock         (clock),
        .resetn        (resetn),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_result     (in_result),
        .in_overflow   (in_overflow),
        .in_not_equal  (in_not_equal),
        .in_less_than  (in_less_than),
        .in_rd         (in_rd),
        .in_pc         (in_pc),
        .in_imm        (in_imm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_rd        (out_rd),
        .out_we        (out_we),
        .out_br_taken  (out_br_taken),
        .out_br_target (out_br_target),
        .ovf_count     (ovf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        op_e         op;
        logic [31:0] result;
        logic        ovf;
        logic        ne;
        logic        lt;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_we;
        logic        e_taken;
        logic [31:0] e_target;
        logic        e_ovf;
        logic        chk_data;
        logic        chk_rd;
    } vec_t;

    typedef struct {
        op_e         op;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
        logic        taken;
        logic [31:0] target;
        logic        ovf;
    } exp_t;

    vec_t vecs[13];
    exp_t model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference transform written directly from the op-class rules.
    function automatic exp_t ref_xform(input op_e op, input logic [31:0] res, input logic ovf,
                                       input logic ne, input logic lt, input logic [4:0] rd,
                                       input logic [31:0] pc, input logic [31:0] imm);
        exp_t e;
        bit   arith;
        bit   raised;
        arith   = (op == ADD) || (op == ADDI) || (op == SUB);
        raised  = arith && ovf;
        e.op    = op;
        e.ovf   = raised;
        if (raised) begin
            e.data = (op == ADD) ? 32'd1 : (op == ADDI) ? 32'd2 : 32'd3;
            e.rd   = 5'd30;
            e.we   = 1'b1;
        end else begin
            e.data = res;
            e.rd   = rd;
            e.we   = (arith || op == LOGIC || op == SHIFT) && (rd != 5'd0);
        end
        e.taken  = (op == BNE && ne) || (op == BLT && lt);
        e.target = 32'((64'(pc) + 64'd1 + 64'(imm)) % 64'h1_0000_0000);
        return e;
    endfunction

    task automatic idle_inputs();
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_op        = NOP;
        in_result    = '0;
        in_overflow  = 1'b0;
        in_not_equal = 1'b0;
        in_less_than = 1'b0;
        in_rd        = '0;
        in_pc        = '0;
        in_imm       = '0;
    endtask

    task automatic set_in(input op_e op, input logic [31:0] res, input logic ovf, input logic [4:0] rd);
        in_op        = op;
        in_result    = res;
        in_overflow  = ovf;
        in_rd        = rd;
        in_not_equal = 1'b0;
        in_less_than = 1'b0;
        in_pc        = '0;
        in_imm       = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        idle_inputs();
        resetn = 1'b0;
        @(negedge clock);
        resetn  = 1'b1;
        cnt_exp = 0;
        model_q.delete();
    endtask

    initial begin
        exp_t e;
        bit   tr;
        bit   acc;

        //            op     result        ovf   ne    lt    rd     pc            imm           e_data        e_rd   we    tk    e_target      eo    cd    cr
        vecs[0]  = '{ADD,   32'd5,        1'b0, 1'b0, 1'b0, 5'd3,  32'd0,        32'd0,        32'd5,        5'd3,  1'b1, 1'b0, 32'd1,        1'b0, 1'b1, 1'b1};
        vecs[1]  = '{SUB,   32'h1234,     1'b1, 1'b0, 1'b0, 5'd7,  32'h100,      32'd0,        32'd3,        5'd30, 1'b1, 1'b0, 32'h101,      1'b1, 1'b1, 1'b1};
        vecs[2]  = '{ADDI,  32'd9,        1'b1, 1'b0, 1'b0, 5'd4,  32'd0,        32'd5,        32'd2,        5'd30, 1'b1, 1'b0, 32'd6,        1'b1, 1'b1, 1'b1};
        vecs[3]  = '{ADD,   32'h10,       1'b1, 1'b0, 1'b0, 5'd1,  32'h20,       32'hFFFFFFFF, 32'd1,        5'd30, 1'b1, 1'b0, 32'h20,       1'b1, 1'b1, 1'b1};
        vecs[4]  = '{BLT,   32'hAA,       1'b0, 1'b0, 1'b1, 5'd9,  32'd10,       32'hFFFFFFFC, 32'hAA,       5'd0,  1'b0, 1'b1, 32'd7,        1'b0, 1'b1, 1'b0};
        vecs[5]  = '{BNE,   32'hBB,       1'b0, 1'b0, 1'b1, 5'd9,  32'd10,       32'd4,        32'hBB,       5'd0,  1'b0, 1'b0, 32'd15,       1'b0, 1'b1, 1'b0};
        vecs[6]  = '{BNE,   32'hCC,       1'b0, 1'b1, 1'b0, 5'd2,  32'hFFFFFFFF, 32'd0,        32'hCC,       5'd0,  1'b0, 1'b1, 32'd0,        1'b0, 1'b1, 1'b0};
        vecs[7]  = '{ADD,   32'd77,       1'b0, 1'b0, 1'b0, 5'd0,  32'd1,        32'd1,        32'd77,       5'd0,  1'b0, 1'b0, 32'd3,        1'b0, 1'b1, 1'b1};
        vecs[8]  = '{LOGIC, 32'hDEAD,     1'b1, 1'b0, 1'b0, 5'd12, 32'd0,        32'd0,        32'hDEAD,     5'd12, 1'b1, 1'b0, 32'd1,        1'b0, 1'b1, 1'b1};
        vecs[9]  = '{SHIFT, 32'h80000000, 1'b1, 1'b0, 1'b0, 5'd5,  32'd2,        32'd2,        32'h80000000, 5'd5,  1'b1, 1'b0, 32'd5,        1'b0, 1'b1, 1'b1};
        vecs[10] = '{NOP,   32'h42,       1'b1, 1'b1, 1'b1, 5'd6,  32'd3,        32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 32'd4,        1'b0, 1'b0, 1'b0};
        vecs[11] = '{BLT,   32'h11,       1'b1, 1'b1, 1'b0, 5'd8,  32'h1000,     32'h10,       32'h11,       5'd0,  1'b0, 1'b0, 32'h1011,     1'b0, 1'b1, 1'b0};
        vecs[12] = '{SUB,   32'h7,        1'b0, 1'b0, 1'b0, 5'd31, 32'd0,        32'h7FFFFFFF, 32'h7,        5'd31, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1};

        // ---------------- reset state ----------------
        idle_inputs();
        out_ready = 1'b0;
        resetn    = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_rd", out_rd, 0);
        check("rst_out_we", out_we, 0);
        check("rst_br_taken", out_br_taken, 0);
        check("rst_br_target", out_br_target, 0);
        check("rst_ovf_count", ovf_count, 0);
        resetn = 1'b1;

        // ---------------- table-driven single entries ----------------
        out_ready = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 13; i++) begin
            in_op        = vecs[i].op;
            in_result    = vecs[i].result;
            in_overflow  = vecs[i].ovf;
            in_not_equal = vecs[i].ne;
            in_less_than = vecs[i].lt;
            in_rd        = vecs[i].rd;
            in_pc        = vecs[i].pc;
            in_imm       = vecs[i].imm;
            in_valid     = 1'b1;
            @(negedge clock);
            in_valid = 1'b0;
            if (vecs[i].e_ovf) cnt_exp++;
            check($sformatf("vec%0d_out_valid", i), out_valid, 1);
            if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), out_data, vecs[i].e_data);
            if (vecs[i].chk_rd)   check($sformatf("vec%0d_rd", i), out_rd, vecs[i].e_rd);
            check($sformatf("vec%0d_we", i), out_we, vecs[i].e_we);
            check($sformatf("vec%0d_taken", i), out_br_taken, vecs[i].e_taken);
            check($sformatf("vec%0d_target", i), out_br_target, vecs[i].e_target);
            check($sformatf("vec%0d_ovf_count", i), ovf_count, cnt_exp);
            @(negedge clock);
            check($sformatf("vec%0d_drained", i), out_valid, 0);
        end

        // ---------------- overflow counter saturation ----------------
        do_reset();
        out_ready = 1'b1;
        set_in(SUB, 32'h99, 1'b1, 5'd7);
        in_valid = 1'b1;
        @(negedge clock);
        check("sat_first_count", ovf_count, 1);
        check("sat_first_data", out_data, 3);
        check("sat_first_rd", out_rd, 30);
        check("sat_first_we", out_we, 1);
        repeat (299) @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        check("sat_count_255", ovf_count, 255);
        cnt_exp = 255;

        // ---------------- back-pressure: A, B accepted, C waits ----------------
        do_reset();
        out_ready = 1'b0;
        set_in(ADD, 32'hA0, 1'b0, 5'd1);
        in_valid = 1'b1;
        @(negedge clock);
        check("bp_c1_out_valid", out_valid, 1);
        check("bp_c1_data_A", out_data, 32'hA0);
        check("bp_c1_in_ready", in_ready, 1);
        set_in(ADD, 32'hB0, 1'b0, 5'd2);
        @(negedge clock);
        check("bp_c2_in_ready", in_ready, 0);
        check("bp_c2_data_A", out_data, 32'hA0);
        set_in(ADD, 32'hC0, 1'b0, 5'd3);
        @(negedge clock);
        check("bp_c3_in_ready", in_ready, 0);
        check("bp_c3_data_A_held", out_data, 32'hA0);
        out_ready = 1'b1;
        @(negedge clock);
        check("bp_c4_data_B", out_data, 32'hB0);
        check("bp_c4_rd_B", out_rd, 2);
        check("bp_c4_in_ready", in_ready, 1);
        @(negedge clock);
        in_valid = 1'b0;
        check("bp_c5_data_C", out_data, 32'hC0);
        check("bp_c5_out_valid", out_valid, 1);
        @(negedge clock);
        check("bp_c6_empty", out_valid, 0);

        // ---------------- flush ----------------
        do_reset();
        out_ready = 1'b0;
        set_in(SUB, 32'h1, 1'b1, 5'd7);
        in_valid = 1'b1;
        @(negedge clock);
        set_in(ADD, 32'h2, 1'b1, 5'd8);
        @(negedge clock);
        check("fl_full_in_ready", in_ready, 0);
        check("fl_full_count", ovf_count, 2);
        set_in(SUB, 32'h3, 1'b1, 5'd9);
        flush = 1'b1;
        @(negedge clock);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_count_kept", ovf_count, 2);
        set_in(ADD, 32'h4, 1'b1, 5'd3);
        in_valid = 1'b1;
        @(negedge clock);
        set_in(SUB, 32'h5, 1'b1, 5'd4);
        flush = 1'b1;
        @(negedge clock);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_acc_out_valid", out_valid, 0);
        check("fl_acc_count", ovf_count, 3);
        out_ready = 1'b1;
        set_in(ADD, 32'h55, 1'b0, 5'd4);
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        check("fl_after_valid", out_valid, 1);
        check("fl_after_data", out_data, 32'h55);

        // ---------------- asynchronous reset during a stall ----------------
        @(negedge clock);
        out_ready = 1'b0;
        set_in(ADD, 32'h66, 1'b1, 5'd2);
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        check("ar_stalled_valid", out_valid, 1);
        #2 resetn = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_out_data", out_data, 0);
        check("ar_in_ready", in_ready, 1);
        check("ar_ovf_count", ovf_count, 0);
        @(negedge clock);
        resetn = 1'b1;

        // ---------------- randomized traffic vs reference model ----------------
        do_reset();
        out_ready = 1'b0;
        @(negedge clock);
        for (int cyc = 0; cyc < 2000; cyc++) begin
            check("rnd_out_valid", out_valid, model_q.size() > 0);
            check("rnd_in_ready", in_ready, model_q.size() < 2);
            check("rnd_ovf_count", ovf_count, cnt_exp);
            if (model_q.size() > 0) begin
                e = model_q[0];
                if (e.op != NOP) check("rnd_data", out_data, e.data);
                if (e.op != NOP && e.op != BNE && e.op != BLT) check("rnd_rd", out_rd, e.rd);
                check("rnd_we", out_we, e.we);
                check("rnd_taken", out_br_taken, e.taken);
                check("rnd_target", out_br_target, e.target);
            end

            in_op        = op_e'($urandom_range(0, 7));
            in_result    = $urandom;
            in_overflow  = $urandom_range(0, 1) == 1;
            in_not_equal = $urandom_range(0, 1) == 1;
            in_less_than = $urandom_range(0, 1) == 1;
            in_rd        = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            in_pc        = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
            in_imm       = $urandom;
            in_valid     = $urandom_range(0, 3) != 0;
            out_ready    = $urandom_range(0, 1) == 1;
            flush        = $urandom_range(0, 15) == 0;

            tr  = (model_q.size() > 0) && out_ready;
            acc = in_valid && (model_q.size() < 2);
            if (flush) begin
                model_q.delete();
            end else begin
                if (tr) void'(model_q.pop_front());
                if (acc) begin
                    e = ref_xform(in_op, in_result, in_overflow, in_not_equal, in_less_than,
                                  in_rd, in_pc, in_imm);
                    model_q.push_back(e);
                    if (e.ovf && cnt_exp < 255) cnt_exp++;
                end
            end
            @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
